// File: rtl/pollard_sequencer.sv
// Control sequencer for Pollard p-1 factoring: builds the exponent once, then tries
// bases 2..1+MAX_BASES through external modexp and gcd engines. Define POLLARD_TIMEOUT_EN to add a per-stage watchdog.
module pollard_sequencer #(
  parameter int unsigned MAX_BASES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] n,
  input  logic [63:0] boundary,
  output logic        ef_start,
  output logic [63:0] ef_boundary,
  input  logic        ef_done,
  input  logic [63:0] ef_e,
  output logic        mx_start,
  output logic [63:0] mx_base,
  output logic [63:0] mx_exp,
  output logic [63:0] mx_mod,
  input  logic        mx_done,
  input  logic [63:0] mx_result,
  output logic        gcd_start,
  output logic [63:0] gcd_a,
  output logic [63:0] gcd_b,
  input  logic        gcd_done,
  input  logic [63:0] gcd_result,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        timeout,
  output logic [63:0] factor
);

  typedef enum logic [2:0] {IDLE, FIND_E, EXP, GCD, CHECK, FINISH} state_e;

  localparam logic [63:0] LAST_BASE = 64'(MAX_BASES) + 64'd1;

  state_e      state_q, state_d;
  logic [63:0] n_q, n_d;
  logic [63:0] bnd_q, bnd_d;
  logic [63:0] e_q, e_d;
  logic [63:0] x_q, x_d;
  logic [63:0] g_q, g_d;
  logic [63:0] base_q, base_d;
  logic [63:0] gcd_a_q, gcd_a_d;
  logic [63:0] factor_q, factor_d;
  logic        found_q, found_d;
  logic        ef_start_q, ef_start_d;
  logic        mx_start_q, mx_start_d;
  logic        gcd_start_q, gcd_start_d;

`ifdef POLLARD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // A done that coincides with its own start pulse belongs to a previous request.
  logic ef_ack, mx_ack, gcd_ack;
  assign ef_ack  = ef_done  && !ef_start_q;
  assign mx_ack  = mx_done  && !mx_start_q;
  assign gcd_ack = gcd_done && !gcd_start_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    n_d         = n_q;
    bnd_d       = bnd_q;
    e_d         = e_q;
    x_d         = x_q;
    g_d         = g_q;
    base_d      = base_q;
    gcd_a_d     = gcd_a_q;
    factor_d    = factor_q;
    found_d     = found_q;
    ef_start_d  = 1'b0;
    mx_start_d  = 1'b0;
    gcd_start_d = 1'b0;
`ifdef POLLARD_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n;
          bnd_d    = boundary;
          base_d   = 64'd2;
          found_d  = 1'b0;
          factor_d = '0;
`ifdef POLLARD_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          // Moduli below 4 have no nontrivial factor worth searching for.
          if (n < 64'd4) begin
            state_d = FINISH;
          end else begin
            state_d    = FIND_E;
            ef_start_d = 1'b1;
          end
        end
      end
      FIND_E: begin
        if (ef_ack) begin
          e_d        = ef_e;
          state_d    = EXP;
          mx_start_d = 1'b1;
        end
      end
      EXP: begin
        if (mx_ack) begin
          x_d         = mx_result;
          gcd_a_d     = (mx_result == 64'd0) ? n_q - 64'd1 : mx_result - 64'd1;
          state_d     = GCD;
          gcd_start_d = 1'b1;
        end
      end
      GCD: begin
        if (gcd_ack) begin
          g_d     = gcd_result;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (g_q > 64'd1 && g_q < n_q) begin
          factor_d = g_q;
          found_d  = 1'b1;
          state_d  = FINISH;
        end else if (g_q == n_q && base_q < LAST_BASE) begin
          // g == n means every prime factor was smooth for this base; retry with the next one.
          base_d     = base_q + 64'd1;
          state_d    = EXP;
          mx_start_d = 1'b1;
        end else begin
          found_d = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef POLLARD_TIMEOUT_EN
    cnt_d = '0;
    if ((state_q == FIND_E || state_q == EXP || state_q == GCD) && state_d == state_q) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        found_d   = 1'b0;
        state_d   = FINISH;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      bnd_q       <= '0;
      e_q         <= '0;
      x_q         <= '0;
      g_q         <= '0;
      base_q      <= '0;
      gcd_a_q     <= '0;
      factor_q    <= '0;
      found_q     <= 1'b0;
      ef_start_q  <= 1'b0;
      mx_start_q  <= 1'b0;
      gcd_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      bnd_q       <= bnd_d;
      e_q         <= e_d;
      x_q         <= x_d;
      g_q         <= g_d;
      base_q      <= base_d;
      gcd_a_q     <= gcd_a_d;
      factor_q    <= factor_d;
      found_q     <= found_d;
      ef_start_q  <= ef_start_d;
      mx_start_q  <= mx_start_d;
      gcd_start_q <= gcd_start_d;
    end
  end

`ifdef POLLARD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign ef_start    = ef_start_q;
  assign ef_boundary = bnd_q;
  assign mx_start    = mx_start_q;
  assign mx_base     = base_q;
  assign mx_exp      = e_q;
  assign mx_mod      = n_q;
  assign gcd_start   = gcd_start_q;
  assign gcd_a       = gcd_a_q;
  assign gcd_b       = n_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign found       = found_q;
  assign factor      = factor_q;

endmodule

// File: tb/tb_pollard_sequencer.sv
// Directed bench for pollard_sequencer: stub engines answer each handshake with
// hand-computed values. Define POLLARD_TIMEOUT_EN to exercise the watchdog build.
module tb_pollard_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] n = '0, boundary = '0;
  logic        ef_start, ef_done = 1'b0;
  logic [63:0] ef_boundary, ef_e = '0;
  logic        mx_start, mx_done = 1'b0;
  logic [63:0] mx_base, mx_exp, mx_mod, mx_result = '0;
  logic        gcd_start, gcd_done = 1'b0;
  logic [63:0] gcd_a, gcd_b, gcd_result = '0;
  logic        busy, done, found, timeout;
  logic [63:0] factor;

  int errors = 0;
  int checks = 0;
  int ef_cnt = 0, mx_cnt = 0, done_cnt = 0;
  logic [63:0] g_tab [8];
  int          mx_lat [8];
  logic [63:0] last_gcd_a;

  pollard_sequencer #(.MAX_BASES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .boundary(boundary),
    .ef_start(ef_start), .ef_boundary(ef_boundary), .ef_done(ef_done), .ef_e(ef_e),
    .mx_start(mx_start), .mx_base(mx_base), .mx_exp(mx_exp), .mx_mod(mx_mod),
    .mx_done(mx_done), .mx_result(mx_result),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_done(gcd_done),
    .gcd_result(gcd_result),
    .busy(busy), .done(done), .found(found), .timeout(timeout), .factor(factor)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ef_start) ef_cnt++;
    if (mx_start) mx_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "bench hung");
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return ef_start;
      1:       return mx_start;
      2:       return gcd_start;
      default: return done;
    endcase
  endfunction

  // Returns how many negedges were waited until the signal was seen (0 = already high), -1 on expiry.
  task automatic wait_for(input int w, input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i <= budget; i++) begin
      if (sig(w)) begin
        cyc = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input logic [63:0] nn, input logic [63:0] bb);
    @(negedge clk);
    start = 1'b1; n = nn; boundary = bb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full run with stub engines; gcd answers come from g_tab, one per base.
  task automatic run(input logic [63:0] nn, input logic [63:0] bb, input logic [63:0] ee,
                     input logic [63:0] xx, input int ng, output bit fin);
    int c;
    logic [63:0] exp_a;
    fin = 1'b0;
    exp_a = (xx == 64'd0) ? nn - 64'd1 : xx - 64'd1;
    pulse_start(nn, bb);
    checks++;
    if (ef_start !== 1'b1 || ef_boundary !== bb) begin
      errors++;
      $display("FAIL ef_latency: ef_start=%0b ef_boundary=%0d, required 1 and %0d", ef_start, ef_boundary, bb);
    end
    checks++;
    if (found !== 1'b0 || factor !== 64'd0) begin
      errors++;
      $display("FAIL start_clear: found=%0b factor=%0d, required 0 and 0", found, factor);
    end
    @(negedge clk); ef_done = 1'b1; ef_e = ee;
    @(negedge clk); ef_done = 1'b0;
    for (int k = 0; k < ng; k++) begin
      wait_for(1, 4, c);
      mx_lat[k] = c;
      checks++;
      if (c < 0 || mx_base !== 64'(k + 2) || mx_exp !== ee || mx_mod !== nn) begin
        errors++;
        $display("FAIL mx_req%0d: wait=%0d base=%0d exp=%0d mod=%0d, required base=%0d exp=%0d mod=%0d",
                 k, c, mx_base, mx_exp, mx_mod, k + 2, ee, nn);
        return;
      end
      @(negedge clk); mx_done = 1'b1; mx_result = xx;
      @(negedge clk); mx_done = 1'b0;
      wait_for(2, 4, c);
      last_gcd_a = gcd_a;
      checks++;
      if (c < 0 || gcd_a !== exp_a || gcd_b !== nn) begin
        errors++;
        $display("FAIL gcd_req%0d: wait=%0d a=%0d b=%0d, required a=%0d b=%0d", k, c, gcd_a, gcd_b, exp_a, nn);
        return;
      end
      @(negedge clk); gcd_done = 1'b1; gcd_result = g_tab[k];
      @(negedge clk); gcd_done = 1'b0;
    end
    wait_for(3, 6, c);
    fin = (c == 1);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL done_latency: waited %0d cycles after last gcd, required 1", c);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, found, timeout, ef_start, mx_start, gcd_start} !== 7'b0 || factor !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b factor=%0d, required all 0",
               {busy, done, found, timeout, ef_start, mx_start, gcd_start}, factor);
    end
    reset = 1'b0;
    @(negedge clk);
    gcd_done = 1'b1; mx_done = 1'b1; ef_done = 1'b1;
    @(negedge clk);
    gcd_done = 1'b0; mx_done = 1'b0; ef_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_done_ignored: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  // 2^60 mod 299 = 170; gcd(169, 299) = 13.
  task automatic test_factor;
    bit fin;
    int d0, m0;
    d0 = done_cnt; m0 = mx_cnt;
    g_tab[0] = 64'd13;
    run(64'd299, 64'd5, 64'd60, 64'd170, 1, fin);
    checks++;
    if (found !== 1'b1 || factor !== 64'd13) begin
      errors++;
      $display("FAIL factor_result: found=%0b factor=%0d, required 1 and 13", found, factor);
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1 || done !== 1'b0 || busy !== 1'b0 || mx_cnt - m0 != 1) begin
      errors++;
      $display("FAIL factor_pulse: done_pulses=%0d done=%0b busy=%0b mx_pulses=%0d, required 1 0 0 1",
               done_cnt - d0, done, busy, mx_cnt - m0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (found !== 1'b1 || factor !== 64'd13) begin
      errors++;
      $display("FAIL factor_hold: found=%0b factor=%0d, required 1 and 13", found, factor);
    end
  endtask

  task automatic test_retry;
    bit fin;
    int e0, m0;
    e0 = ef_cnt; m0 = mx_cnt;
    g_tab[0] = 64'd299; g_tab[1] = 64'd299; g_tab[2] = 64'd299; g_tab[3] = 64'd23;
    run(64'd299, 64'd5, 64'd60, 64'd170, 4, fin);
    @(negedge clk); #1;
    checks++;
    if (mx_cnt - m0 != 4 || ef_cnt - e0 != 1) begin
      errors++;
      $display("FAIL retry_pulses: mx=%0d ef=%0d, required 4 and 1", mx_cnt - m0, ef_cnt - e0);
    end
    checks++;
    if (found !== 1'b1 || factor !== 64'd23) begin
      errors++;
      $display("FAIL retry_result: found=%0b factor=%0d, required 1 and 23", found, factor);
    end
    checks++;
    if (mx_lat[1] != 1 || mx_lat[2] != 1 || mx_lat[3] != 1) begin
      errors++;
      $display("FAIL retry_latency: %0d %0d %0d, required 1 1 1", mx_lat[1], mx_lat[2], mx_lat[3]);
    end
  endtask

  task automatic test_no_factor;
    bit fin;
    int m0;
    m0 = mx_cnt;
    g_tab[0] = 64'd1;
    run(64'd299, 64'd5, 64'd60, 64'd170, 1, fin);
    @(negedge clk); #1;
    checks++;
    if (found !== 1'b0 || mx_cnt - m0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL g_one: found=%0b mx=%0d busy=%0b, required 0 1 0", found, mx_cnt - m0, busy);
    end
    m0 = mx_cnt;
    for (int i = 0; i < 4; i++) g_tab[i] = 64'd299;
    run(64'd299, 64'd5, 64'd60, 64'd170, 4, fin);
    @(negedge clk); #1;
    checks++;
    if (found !== 1'b0 || factor !== 64'd0 || mx_cnt - m0 != 4) begin
      errors++;
      $display("FAIL exhausted: found=%0b factor=%0d mx=%0d, required 0 0 4", found, factor, mx_cnt - m0);
    end
  endtask

  task automatic test_zero_x;
    bit fin;
    g_tab[0] = 64'd1;
    run(64'd299, 64'd5, 64'd60, 64'd0, 1, fin);
    checks++;
    if (last_gcd_a !== 64'd298) begin
      errors++;
      $display("FAIL zero_x_gcd_a: got %0d, required 298", last_gcd_a);
    end
  endtask

  task automatic test_small_n;
    int e0;
    e0 = ef_cnt;
    pulse_start(64'd3, 64'd5);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || found !== 1'b0 || ef_start !== 1'b0) begin
      errors++;
      $display("FAIL small_n_finish: done=%0b busy=%0b found=%0b ef_start=%0b, required 1 1 0 0",
               done, busy, found, ef_start);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ef_cnt != e0) begin
      errors++;
      $display("FAIL small_n_idle: done=%0b busy=%0b ef_pulses=%0d, required 0 0 0", done, busy, ef_cnt - e0);
    end
  endtask

  task automatic test_ignore;
    pulse_start(64'd299, 64'd7);
    ef_done = 1'b1; ef_e = 64'd99;
    start = 1'b1; n = 64'd15;
    @(negedge clk);
    ef_done = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mx_start !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_done: busy=%0b mx_start=%0b, required 1 0", busy, mx_start);
    end
    ef_done = 1'b1; ef_e = 64'd60;
    @(negedge clk);
    ef_done = 1'b0;
    checks++;
    if (mx_start !== 1'b1 || mx_exp !== 64'd60 || mx_mod !== 64'd299) begin
      errors++;
      $display("FAIL busy_start_ignored: mx_start=%0b exp=%0d mod=%0d, required 1 60 299", mx_start, mx_exp, mx_mod);
    end
    #2 reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset_midrun;
    bit fin;
    pulse_start(64'd299, 64'd5);
    @(negedge clk); ef_done = 1'b1; ef_e = 64'd60;
    @(negedge clk); ef_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, found, timeout, mx_start, gcd_start} !== 6'b0 || factor !== 64'd0 || mx_base !== 64'd0 || mx_exp !== 64'd0) begin
      errors++;
      $display("FAIL reset_midrun: flags=%b factor=%0d base=%0d exp=%0d, required all 0",
               {busy, done, found, timeout, mx_start, gcd_start}, factor, mx_base, mx_exp);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); mx_done = 1'b1; mx_result = 64'd170;
    @(negedge clk); mx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gcd_start !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL late_done: busy=%0b gcd_start=%0b done=%0b, required 0 0 0", busy, gcd_start, done);
    end
    g_tab[0] = 64'd13;
    run(64'd299, 64'd5, 64'd60, 64'd170, 1, fin);
    checks++;
    if (found !== 1'b1 || factor !== 64'd13) begin
      errors++;
      $display("FAIL after_reset_run: found=%0b factor=%0d, required 1 and 13", found, factor);
    end
  endtask

  task automatic test_timeout;
    int c;
    int seen;
    pulse_start(64'd299, 64'd5);
    @(negedge clk); ef_done = 1'b1; ef_e = 64'd60;
    @(negedge clk); ef_done = 1'b0;
    @(negedge clk); mx_done = 1'b1; mx_result = 64'd170;
    @(negedge clk); mx_done = 1'b0;
    wait_for(2, 4, c);
    seen = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = i;
        break;
      end
    end
`ifdef POLLARD_TIMEOUT_EN
    checks++;
    if (c < 0 || seen != 16 || timeout !== 1'b1 || found !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: gcd_wait=%0d done_after=%0d timeout=%0b found=%0b, required 16 1 0",
               c, seen, timeout, found);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold: timeout=%0b busy=%0b, required 1 0", timeout, busy);
    end
`else
    checks++;
    if (c < 0 || seen != -1 || busy !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: gcd_wait=%0d done_after=%0d busy=%0b timeout=%0b, required no done 1 0",
               c, seen, busy, timeout);
    end
    #2 reset = 1'b1;
    @(negedge clk); reset = 1'b0;
`endif
  endtask

  initial begin
    test_reset;
    test_factor;
    test_retry;
    test_no_factor;
    test_zero_x;
    test_small_n;
    test_ignore;
    test_reset_midrun;
    test_timeout;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
